event_time_capture: RTL and testbench

- Downstream consumer of the PPS/time-base stage: timestamps external event edges against the local disciplined time (seconds + 100 ns sub-second count) and queues the records for the CPU/bus interface.
- Adds a clk-cycle fine count within each 100 ns tick, a glitch filter and a drop/overflow status.

---
 rtl/event_time_capture.sv | 137 +++++++++++++
 tb/tb_event_time_capture.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_time_capture.sv
// Timestamps filtered edges of an asynchronous event input against the local time base
// and queues {seconds, sub-second, fine count, polarity} records in a show-ahead FIFO.
module event_time_capture #(
  parameter int FILT_LEN = 4,
  parameter int DEPTH    = 16,
  parameter int CNT_W    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt_in,
  input  logic [1:0]       edge_sel,
  input  logic             cap_en,
  input  logic [31:0]      tim_s,
  input  logic [31:0]      tim_sub,
  input  logic             rd_en,
  input  logic             clr_stat,
  output logic             rd_valid,
  output logic [31:0]      rd_s,
  output logic [23:0]      rd_sub,
  output logic [3:0]       rd_fine,
  output logic             rd_pol,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = 32 + 24 + 4 + 1;

  logic             evt_meta, evt_sync, evt_filt, evt_filt_d;
  logic [3:0]       filt_cnt;
  logic             rise, fall, cap;
  logic [31:0]      tim_sub_d;
  logic [3:0]       fine_q, fine_now;
  logic [REC_W-1:0] rec, head_q, head_next;
  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, next_rd_ptr;
  logic [CNT_W-1:0] next_count;
  logic             full, pop, wr, drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_meta   <= 1'b0;
      evt_sync   <= 1'b0;
      evt_filt   <= 1'b0;
      evt_filt_d <= 1'b0;
      filt_cnt   <= '0;
    end else begin
      evt_meta   <= evt_in;
      evt_sync   <= evt_meta;
      evt_filt_d <= evt_filt;
      if (evt_sync == evt_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == 4'(FILT_LEN - 1)) begin
        evt_filt <= ~evt_filt;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end
  end

  assign rise = evt_filt & ~evt_filt_d;
  assign fall = ~evt_filt & evt_filt_d;
  assign cap  = cap_en & ((rise & edge_sel[0]) | (fall & edge_sel[1]));

  // fine_now is the count for the current cycle: 0 in the cycle tim_sub changes, so a
  // capture on a 100 ns boundary never pairs the new tim_sub with a stale fine count.
  always_comb begin
    if (tim_sub != tim_sub_d)  fine_now = 4'd0;
    else if (fine_q == 4'd15)  fine_now = 4'd15;
    else                       fine_now = fine_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tim_sub_d <= '0;
      fine_q    <= '0;
    end else begin
      tim_sub_d <= tim_sub;
      fine_q    <= fine_now;
    end
  end

  assign rec         = {tim_s, tim_sub[23:0], fine_now, rise};
  assign rd_valid    = (fifo_count != '0);
  assign full        = (fifo_count == CNT_W'(DEPTH));
  assign pop         = rd_en & rd_valid;
  assign wr          = cap & (~full | pop);
  assign drop        = cap & ~wr;
  assign next_rd_ptr = rd_ptr + AW'(pop);
  assign next_count  = fifo_count + CNT_W'(wr) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= rec;
  end

  // The head register is loaded with whatever will sit at the read pointer next cycle;
  // a record being written into an otherwise empty FIFO bypasses the memory.
  always_comb begin
    head_next = head_q;
    if (next_count != '0) begin
      if (wr && (next_rd_ptr == wr_ptr)) head_next = rec;
      else                               head_next = mem[next_rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      head_q     <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= next_rd_ptr;
      fifo_count <= next_count;
      head_q     <= head_next;
    end
  end

  assign {rd_s, rd_sub, rd_fine, rd_pol} = head_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_stat) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_event_time_capture.sv
// Self-checking bench for event_time_capture: directed scenarios plus random traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_event_time_capture;

  localparam int FILT_LEN = 4;
  localparam int DEPTH    = 16;
  localparam int CNT_W    = 9;
  localparam int LAT      = 2 + FILT_LEN + 1;

  typedef struct packed {
    logic [31:0] s;
    logic [23:0] sub;
    logic [3:0]  fine;
    logic        pol;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             evt_in = 1'b0;
  logic [1:0]       edge_sel = 2'b00;
  logic             cap_en = 1'b0;
  logic [31:0]      tim_s = 32'd0;
  logic [31:0]      tim_sub = 32'd0;
  logic             rd_en = 1'b0;
  logic             clr_stat = 1'b0;
  logic             rd_valid;
  logic [31:0]      rd_s;
  logic [23:0]      rd_sub;
  logic [3:0]       rd_fine;
  logic             rd_pol;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;
  logic [7:0]       drop_cnt;

  int errors = 0;
  int checks = 0;

  event_time_capture #(.FILT_LEN(FILT_LEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .evt_in(evt_in), .edge_sel(edge_sel), .cap_en(cap_en),
    .tim_s(tim_s), .tim_sub(tim_sub), .rd_en(rd_en), .clr_stat(clr_stat),
    .rd_valid(rd_valid), .rd_s(rd_s), .rd_sub(rd_sub), .rd_fine(rd_fine), .rd_pol(rd_pol),
    .fifo_count(fifo_count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #4 clk = ~clk;

  // Time base: mode 0 holds set_s/set_sub, mode 1 ticks every 12/13 clocks, mode 2 every clock.
  int          tim_mode = 0;
  logic [31:0] set_s = 32'd0;
  logic [31:0] set_sub = 32'd0;
  int          tick_ph = 0;
  int          tick_per = 12;

  task automatic advance_time();
    if (tim_sub == 32'd9_999_999) begin
      tim_sub = 32'd0;
      tim_s   = tim_s + 32'd1;
    end else begin
      tim_sub = tim_sub + 32'd1;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (tim_mode == 0) begin
      tim_s   = set_s;
      tim_sub = set_sub;
    end else if (tim_mode == 2) begin
      advance_time();
    end else begin
      tick_ph++;
      if (tick_ph >= tick_per) begin
        tick_ph  = 0;
        tick_per = (tick_per == 12) ? 13 : 12;
        advance_time();
      end
    end
  end

  // Behavioural model state
  bit          hist[$];
  bit          m_filt, m_filt_prev;
  int          streak;
  int          m_fine;
  logic [31:0] prev_sub;
  rec_t        q[$];
  rec_t        last_head;
  bit          m_ovf;
  int          m_drops;

  task automatic model_reset();
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
    m_filt = 0; m_filt_prev = 0; streak = 0; m_fine = 0; prev_sub = '0;
    q.delete(); last_head = '0; m_ovf = 0; m_drops = 0;
  endtask

  task automatic model_step();
    bit   rise, fall, cap, sample, popm, wrm;
    rec_t r;
    if (tim_sub != prev_sub) m_fine = 0;
    else if (m_fine < 15)    m_fine++;
    prev_sub = tim_sub;
    rise = m_filt && !m_filt_prev;
    fall = !m_filt && m_filt_prev;
    cap  = cap_en && ((rise && edge_sel[0]) || (fall && edge_sel[1]));
    sample = hist.pop_front();
    hist.push_back(evt_in);
    m_filt_prev = m_filt;
    // The filtered level flips once FILT_LEN consecutive synchronized samples disagree with it.
    if (sample != m_filt) begin
      streak++;
      if (streak == FILT_LEN) begin
        m_filt = !m_filt;
        streak = 0;
      end
    end else begin
      streak = 0;
    end
    r.s = tim_s; r.sub = tim_sub[23:0]; r.fine = 4'(m_fine); r.pol = rise;
    popm = rd_en && (q.size() > 0);
    wrm  = cap && ((q.size() < DEPTH) || popm);
    if (popm) void'(q.pop_front());
    if (wrm)  q.push_back(r);
    if (clr_stat) begin
      m_ovf = 0; m_drops = 0;
    end else if (cap && !wrm) begin
      m_ovf = 1;
      if (m_drops < 255) m_drops++;
    end
    if (q.size() > 0) last_head = q[0];
  endtask

  task automatic check_output();
    rec_t got;
    got = {rd_s, rd_sub, rd_fine, rd_pol};
    checks++;
    if (rd_valid !== (q.size() > 0)) begin
      errors++;
      $display("[TB] FAIL rd_valid t=%0t got=%0b exp=%0b", $time, rd_valid, q.size() > 0);
    end
    checks++;
    if (got !== last_head) begin
      errors++;
      $display("[TB] FAIL head t=%0t got s=%0d sub=%0d fine=%0d pol=%0b exp s=%0d sub=%0d fine=%0d pol=%0b",
               $time, got.s, got.sub, got.fine, got.pol, last_head.s, last_head.sub, last_head.fine, last_head.pol);
    end
    checks++;
    if ((int'(fifo_count) != q.size()) || (overflow !== m_ovf) || (int'(drop_cnt) != m_drops)) begin
      errors++;
      $display("[TB] FAIL status t=%0t got count=%0d ovf=%0b drops=%0d exp count=%0d ovf=%0b drops=%0d",
               $time, fifo_count, overflow, drop_cnt, q.size(), m_ovf, m_drops);
    end
  endtask

  always @(posedge clk) begin
    if (rst) model_reset();
    else     model_step();
    #2;
    check_output();
  end

  task automatic check_val(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  task automatic pop_one();
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
  endtask

  task automatic pulse(input int hi, input int lo);
    @(negedge clk) evt_in = 1'b1;
    repeat (hi) @(negedge clk);
    evt_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #2;
      n++;
      if (rd_valid) break;
    end
    if (!rd_valid) check_val({name, "_timeout"}, 0, 1);
  endtask

  int n, hold;
  logic [23:0] sub1;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_val("reset_valid", int'(rd_valid), 0);
    check_val("reset_count", int'(fifo_count), 0);
    rst = 1'b0;

    // Rising-edge capture, falling edge ignored
    set_s = 32'd100; set_sub = 32'd5000;
    repeat (2) @(negedge clk);
    tim_mode = 1; edge_sel = 2'b01; cap_en = 1'b1;
    repeat (20) @(negedge clk);
    evt_in = 1'b1;
    wait_valid("rise", n);
    check_val("rise_latency", n, LAT);
    check_val("rise_pol", int'(rd_pol), 1);
    check_val("rise_s", rd_s, 100);
    check_val("rise_fine_range", int'(rd_fine <= 4'd12), 1);
    repeat (4) @(negedge clk);
    evt_in = 1'b0;
    repeat (15) @(negedge clk);
    check_val("fall_ignored", int'(fifo_count), 1);
    pop_one();

    // Glitch rejection and both-edge capture with a per-clock time base
    tim_mode = 2; edge_sel = 2'b11;
    pulse(3, 15);
    check_val("glitch_count", int'(fifo_count), 0);
    pulse(5, 15);
    check_val("pulse_count", int'(fifo_count), 2);
    check_val("pulse_pol1", int'(rd_pol), 1);
    sub1 = rd_sub;
    pop_one();
    check_val("pulse_pol0", int'(rd_pol), 0);
    check_val("pulse_sep", rd_sub - sub1, 5);
    pop_one();

    // Event captured exactly in the cycle the second rolls over
    tim_mode = 0; set_s = 32'd100; set_sub = 32'd9_999_999; edge_sel = 2'b01;
    repeat (10) @(negedge clk);
    evt_in = 1'b1;
    repeat (5) @(negedge clk);
    set_s = 32'd101; set_sub = 32'd0;
    wait_valid("boundary", n);
    check_val("boundary_s", rd_s, 101);
    check_val("boundary_sub", rd_sub, 0);
    check_val("boundary_fine", rd_fine, 0);
    @(negedge clk) evt_in = 1'b0;
    repeat (12) @(negedge clk);
    pop_one();

    // Overflow: 20 events into a 16-deep FIFO
    tim_mode = 1;
    for (int i = 0; i < 20; i++) pulse(5, 5);
    repeat (12) @(negedge clk);
    check_val("ovf_count", int'(fifo_count), DEPTH);
    check_val("ovf_flag", int'(overflow), 1);
    check_val("ovf_drops", int'(drop_cnt), 4);

    // Full FIFO with pop in the capture cycle
    @(negedge clk) evt_in = 1'b1;
    repeat (6) @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
    check_val("fullpop_count", int'(fifo_count), DEPTH);
    check_val("fullpop_drops", int'(drop_cnt), 4);
    evt_in = 1'b0;
    repeat (12) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) pop_one();
    check_val("drain_count", int'(fifo_count), 0);
    @(negedge clk) clr_stat = 1'b1;
    @(negedge clk) clr_stat = 1'b0;
    check_val("clr_ovf", int'(overflow), 0);
    check_val("clr_drops", int'(drop_cnt), 0);

    // Reset with records queued; no capture too early after release
    for (int i = 0; i < 3; i++) pulse(5, 5);
    repeat (10) @(negedge clk);
    check_val("preq_count", int'(fifo_count), 3);
    @(negedge clk);
    evt_in = 1'b1;
    rst = 1'b1;
    #1;
    check_val("mid_reset_valid", int'(rd_valid), 0);
    check_val("mid_reset_count", int'(fifo_count), 0);
    check_val("mid_reset_s", rd_s, 0);
    check_val("mid_reset_drops", int'(drop_cnt), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      @(negedge clk);
      check_val("post_reset_quiet", int'(fifo_count), 0);
    end
    repeat (5) @(negedge clk);
    check_val("post_reset_capture", int'(fifo_count), 1);
    evt_in = 1'b0;
    repeat (10) @(negedge clk);
    pop_one();

    // Random traffic near a second rollover
    tim_mode = 0; set_s = 32'd7; set_sub = 32'd9_999_990;
    repeat (2) @(negedge clk);
    tim_mode = 1;
    hold = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hold--;
      if (hold <= 0) begin
        evt_in = ~evt_in;
        hold = int'($urandom_range(1, 9));
      end
      rd_en    = ($urandom % 3) == 0;
      clr_stat = ($urandom % 50) == 0;
      if ((c % 100) == 0) begin
        edge_sel = 2'($urandom);
        cap_en   = ($urandom % 4) != 0;
      end
    end
    rd_en = 1'b0; clr_stat = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

endmodule
